// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the IF/MEM unified-memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned MAX_WAIT_CYCLES = 15;
  localparam int unsigned MAX_STARVE      = 15;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned PERF_W          = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_id_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc16(input logic [PERF_W-1:0] v);
    return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-port signals of the arbiter; slave is the arbiter view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, d_rdata, d_ready,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive fetch losses; sat_c forces the next fetch grant.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat_c
);

  logic [CNT_W-1:0] cnt;

  assign sat_c = (cnt >= CNT_W'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data accesses onto one single-ported memory bank.
// Optional ARB_PERF_EN adds per-requester wait-cycle counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_port_arbiter_if.slave     bus
`ifdef ARB_PERF_EN
  ,
  output logic [PERF_W-1:0]     if_wait_cnt,
  output logic [PERF_W-1:0]     d_wait_cnt
`endif
);

  arb_state_t        state;
  gnt_id_t           gnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  wcnt;

  logic              if_ready_q;
  logic              d_ready_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              busy_q;

  logic              grant_c;
  gnt_id_t           gnt_c;
  logic              starve_inc_c;
  logic              starve_clr_c;
  logic              starve_sat_c;
  logic              access_c;
  logic              wr_c;

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (starve_inc_c),
    .clr  (starve_clr_c),
    .sat_c(starve_sat_c)
  );

  // Data wins unless fetch has lost STARVE_MAX times in a row.
  always_comb begin
    grant_c      = 1'b0;
    gnt_c        = GNT_IF;
    starve_inc_c = 1'b0;
    starve_clr_c = 1'b0;
    if (state == IDLE) begin
      if (bus.d_req && !starve_sat_c) begin
        grant_c      = 1'b1;
        gnt_c        = GNT_D;
        starve_inc_c = bus.if_req;
      end else if (bus.if_req) begin
        grant_c      = 1'b1;
        gnt_c        = GNT_IF;
        starve_clr_c = 1'b1;
      end else if (bus.d_req) begin
        grant_c      = 1'b1;
        gnt_c        = GNT_D;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_q      <= GNT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wcnt       <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_c) begin
            state  <= ACCESS;
            busy_q <= 1'b1;
            gnt_q  <= gnt_c;
            wcnt   <= '0;
            if (gnt_c == GNT_D) begin
              addr_q  <= bus.d_addr;
              we_q    <= bus.d_we;
              wdata_q <= bus.d_wdata;
            end else begin
              addr_q  <= bus.if_addr;
              we_q    <= 1'b0;
              wdata_q <= '0;
            end
          end
        end
        ACCESS: begin
          wcnt <= wcnt + CNT_W'(1);
          // Last held cycle: memory data is stable, capture it into the response.
          if (wcnt == CNT_W'(WAIT_CYCLES - 1)) begin
            state <= RESP;
            if (gnt_q == GNT_D) begin
              d_ready_q <= 1'b1;
              d_rdata_q <= we_q ? '0 : bus.mem_rdata;
            end else begin
              if_ready_q <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
          end
        end
        RESP: begin
          state      <= IDLE;
          busy_q     <= 1'b0;
          if_ready_q <= 1'b0;
          d_ready_q  <= 1'b0;
          if_rdata_q <= '0;
          d_rdata_q  <= '0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign access_c = (state == ACCESS);
  assign wr_c     = access_c && (gnt_q == GNT_D) && we_q;

  assign bus.mem_en    = access_c;
  assign bus.mem_we    = wr_c;
  assign bus.mem_addr  = access_c ? addr_q : '0;
  assign bus.mem_wdata = wr_c ? wdata_q : '0;

  assign bus.if_ready = if_ready_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_ready  = d_ready_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.busy     = busy_q;

`ifdef ARB_PERF_EN
  logic [PERF_W-1:0] if_wait_q;
  logic [PERF_W-1:0] d_wait_q;

  // Cycles a requester is asking but not being served.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_wait_q <= '0;
      d_wait_q  <= '0;
    end else begin
      if (bus.if_req && !if_ready_q) if_wait_q <= sat_inc16(if_wait_q);
      if (bus.d_req && !d_ready_q)   d_wait_q  <= sat_inc16(d_wait_q);
    end
  end

  assign if_wait_cnt = if_wait_q;
  assign d_wait_cnt  = d_wait_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: cycle table on a WAIT_CYCLES=1 arbiter plus starvation,
// blocked-fetch and mid-access-reset sequences (reset case on WAIT_CYCLES=3).
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n;
  logic rst_b_n;
  logic mem_init;

  int total  = 0;
  int passed = 0;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) a_if ();
  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) b_if ();

  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];

  assign a_if.mem_rdata = mem_a[a_if.mem_addr[7:2]];
  assign b_if.mem_rdata = mem_b[b_if.mem_addr[7:2]];

  // Memory models: preload while mem_init, otherwise write on enabled write cycles.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        mem_a[i] <= 32'h0;
        mem_b[i] <= 32'h0;
      end
      mem_a[1] <= 32'h8C010000;
      mem_b[1] <= 32'h8C010000;
    end else begin
      if (a_if.mem_en && a_if.mem_we) mem_a[a_if.mem_addr[7:2]] <= a_if.mem_wdata;
      if (b_if.mem_en && b_if.mem_we) mem_b[b_if.mem_addr[7:2]] <= b_if.mem_wdata;
    end
  end

`ifdef ARB_PERF_EN
  logic [15:0] a_if_wait, a_d_wait, b_if_wait, b_d_wait;
`endif

  mem_port_arbiter #(
    .ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(1), .STARVE_MAX(4)
  ) u_dut_a (
    .clk  (clk),
    .rst_n(rst_a_n),
    .bus  (a_if)
`ifdef ARB_PERF_EN
    ,
    .if_wait_cnt(a_if_wait),
    .d_wait_cnt (a_d_wait)
`endif
  );

  mem_port_arbiter #(
    .ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(3), .STARVE_MAX(4)
  ) u_dut_b (
    .clk  (clk),
    .rst_n(rst_b_n),
    .bus  (b_if)
`ifdef ARB_PERF_EN
    ,
    .if_wait_cnt(b_if_wait),
    .d_wait_cnt (b_d_wait)
`endif
  );

  typedef struct {
    logic        if_req;
    logic [7:0]  if_addr;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic        e_if_ready;
    logic [31:0] e_if_rdata;
    logic        e_d_ready;
    logic [31:0] e_d_rdata;
    logic        e_mem_en;
    logic        e_mem_we;
    logic [7:0]  e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic        e_busy;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic ir, input logic [7:0] ia, input logic dr, input logic dw,
    input logic [7:0] da, input logic [31:0] dd,
    input logic eir, input logic [31:0] eid, input logic edr, input logic [31:0] edd,
    input logic een, input logic ewe, input logic [7:0] ead, input logic [31:0] ewd,
    input logic eb);
    vec_t v;
    v.if_req = ir;  v.if_addr = ia;  v.d_req = dr;  v.d_we = dw;
    v.d_addr = da;  v.d_wdata = dd;
    v.e_if_ready = eir; v.e_if_rdata = eid; v.e_d_ready = edr; v.e_d_rdata = edd;
    v.e_mem_en = een; v.e_mem_we = ewe; v.e_mem_addr = ead; v.e_mem_wdata = ewd;
    v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive_a(input logic ir, input logic [7:0] ia, input logic dr,
                         input logic dw, input logic [7:0] da, input logic [31:0] dd);
    a_if.if_req = ir; a_if.if_addr = ia; a_if.d_req = dr;
    a_if.d_we = dw;   a_if.d_addr = da;  a_if.d_wdata = dd;
  endtask

  logic [1:0] got [0:15];
  int ngr;

  initial begin
    vecs[0]  = mk(1,8'h04,0,0,8'h00,32'h0,        0,32'h0,0,32'h0,        0,0,8'h00,32'h0,1'b0);
    vecs[1]  = mk(1,8'h04,0,0,8'h00,32'h0,        0,32'h0,0,32'h0,        1,0,8'h04,32'h0,1'b1);
    vecs[2]  = mk(1,8'h04,0,0,8'h00,32'h0,        1,32'h8C010000,0,32'h0, 0,0,8'h00,32'h0,1'b1);
    vecs[3]  = mk(0,8'h00,0,0,8'h00,32'h0,        0,32'h0,0,32'h0,        0,0,8'h00,32'h0,1'b0);
    vecs[4]  = mk(1,8'h04,1,1,8'h10,32'hDEADBEEF, 0,32'h0,0,32'h0,        0,0,8'h00,32'h0,1'b0);
    vecs[5]  = mk(1,8'h04,1,1,8'h10,32'hDEADBEEF, 0,32'h0,0,32'h0,        1,1,8'h10,32'hDEADBEEF,1'b1);
    vecs[6]  = mk(1,8'h04,1,1,8'h10,32'hDEADBEEF, 0,32'h0,1,32'h0,        0,0,8'h00,32'h0,1'b1);
    vecs[7]  = mk(1,8'h04,0,0,8'h00,32'h0,        0,32'h0,0,32'h0,        0,0,8'h00,32'h0,1'b0);
    vecs[8]  = mk(1,8'h04,0,0,8'h00,32'h0,        0,32'h0,0,32'h0,        1,0,8'h04,32'h0,1'b1);
    vecs[9]  = mk(1,8'h04,0,0,8'h00,32'h0,        1,32'h8C010000,0,32'h0, 0,0,8'h00,32'h0,1'b1);
    vecs[10] = mk(0,8'h00,0,0,8'h00,32'h0,        0,32'h0,0,32'h0,        0,0,8'h00,32'h0,1'b0);
    vecs[11] = mk(0,8'h00,1,0,8'h10,32'h0,        0,32'h0,0,32'h0,        0,0,8'h00,32'h0,1'b0);
    vecs[12] = mk(0,8'h00,1,0,8'h10,32'h0,        0,32'h0,0,32'h0,        1,0,8'h10,32'h0,1'b1);
    vecs[13] = mk(0,8'h00,1,0,8'h10,32'h0,        0,32'h0,1,32'hDEADBEEF, 0,0,8'h00,32'h0,1'b1);
    vecs[14] = mk(0,8'h00,0,0,8'h00,32'h0,        0,32'h0,0,32'h0,        0,0,8'h00,32'h0,1'b0);

    mem_init = 1'b1;
    rst_a_n  = 1'b0;
    rst_b_n  = 1'b0;
    drive_a(0, 8'h00, 0, 0, 8'h00, 32'h0);
    b_if.if_req = 1'b0; b_if.if_addr = 8'h00; b_if.d_req = 1'b0;
    b_if.d_we = 1'b0;   b_if.d_addr = 8'h00;  b_if.d_wdata = 32'h0;
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    rst_a_n  = 1'b1;
    rst_b_n  = 1'b1;
    #1;
    chk("reset_busy",     32'(a_if.busy),     32'h0);
    chk("reset_if_ready", 32'(a_if.if_ready), 32'h0);
    chk("reset_d_ready",  32'(a_if.d_ready),  32'h0);
    chk("reset_mem_en",   32'(a_if.mem_en),   32'h0);

    // Cycle table: single fetch, simultaneous write+fetch, read-back of the write.
    for (int k = 0; k < NVEC; k++) begin
      @(negedge clk);
      drive_a(vecs[k].if_req, vecs[k].if_addr, vecs[k].d_req,
              vecs[k].d_we, vecs[k].d_addr, vecs[k].d_wdata);
      #1;
      chk($sformatf("row%0d_if_ready", k),  32'(a_if.if_ready),  32'(vecs[k].e_if_ready));
      chk($sformatf("row%0d_if_rdata", k),  a_if.if_rdata,       vecs[k].e_if_rdata);
      chk($sformatf("row%0d_d_ready", k),   32'(a_if.d_ready),   32'(vecs[k].e_d_ready));
      chk($sformatf("row%0d_d_rdata", k),   a_if.d_rdata,        vecs[k].e_d_rdata);
      chk($sformatf("row%0d_mem_en", k),    32'(a_if.mem_en),    32'(vecs[k].e_mem_en));
      chk($sformatf("row%0d_mem_we", k),    32'(a_if.mem_we),    32'(vecs[k].e_mem_we));
      chk($sformatf("row%0d_mem_addr", k),  32'(a_if.mem_addr),  32'(vecs[k].e_mem_addr));
      chk($sformatf("row%0d_mem_wdata", k), a_if.mem_wdata,      vecs[k].e_mem_wdata);
      chk($sformatf("row%0d_busy", k),      32'(a_if.busy),      32'(vecs[k].e_busy));
    end

    // Starvation: both requests held; expect D,D,D,D,I repeating.
    ngr = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      drive_a(1, 8'h04, 1, 0, 8'h20, 32'h0);
      #1;
      if (a_if.mem_en && ngr < 16) begin
        got[ngr] = (a_if.mem_addr == 8'h04) ? 2'd1 : 2'd2;
        ngr++;
      end
    end
    chk("starve_grant_count", 32'(ngr), 32'd15);
    for (int g = 0; g < 15; g++) begin
      chk($sformatf("starve_grant%0d", g), 32'(got[g]), (g % 5 == 4) ? 32'd1 : 32'd2);
    end

    @(negedge clk);
    drive_a(0, 8'h00, 0, 0, 8'h00, 32'h0);
    rst_a_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    #1;
    chk("rearm_busy", 32'(a_if.busy), 32'h0);

    // Fetch blocked behind one data read.
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c <= 2) drive_a(1, 8'h04, 1, 0, 8'h10, 32'h0);
      else if (c <= 5) drive_a(1, 8'h04, 0, 0, 8'h00, 32'h0);
      else drive_a(0, 8'h00, 0, 0, 8'h00, 32'h0);
      #1;
      chk($sformatf("blk%0d_d_ready", c),  32'(a_if.d_ready),  (c == 2) ? 32'h1 : 32'h0);
      chk($sformatf("blk%0d_if_ready", c), 32'(a_if.if_ready), (c == 5) ? 32'h1 : 32'h0);
`ifdef ARB_PERF_EN
      if (c == 2) chk("perf_d_wait",  32'(a_d_wait),  32'd2);
      if (c == 5) chk("perf_if_wait", 32'(a_if_wait), 32'd5);
`endif
    end
    chk("blk_d_rdata_idle", a_if.d_rdata, 32'h0);

    // WAIT_CYCLES=3: reset in the 2nd ACCESS cycle, then the held fetch restarts.
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      b_if.if_req  = (c <= 7);
      b_if.if_addr = 8'h04;
      rst_b_n      = (c != 2);
      #1;
      if (c == 0) chk("rb_idle_busy", 32'(b_if.busy), 32'h0);
      if (c == 1 || c == 2) chk($sformatf("rb%0d_mem_en", c), 32'(b_if.mem_en), 32'h1);
      if (c == 3) begin
        chk("rb3_mem_en",   32'(b_if.mem_en),   32'h0);
        chk("rb3_busy",     32'(b_if.busy),     32'h0);
        chk("rb3_if_ready", 32'(b_if.if_ready), 32'h0);
      end
      if (c >= 4 && c <= 6) begin
        chk($sformatf("rb%0d_mem_en", c),   32'(b_if.mem_en),   32'h1);
        chk($sformatf("rb%0d_if_ready", c), 32'(b_if.if_ready), 32'h0);
      end
      if (c == 7) begin
        chk("rb7_if_ready", 32'(b_if.if_ready), 32'h1);
        chk("rb7_if_rdata", b_if.if_rdata,      32'h8C010000);
        chk("rb7_mem_en",   32'(b_if.mem_en),   32'h0);
        chk("rb7_d_ready",  32'(b_if.d_ready),  32'h0);
      end
      if (c == 8) chk("rb8_if_ready", 32'(b_if.if_ready), 32'h0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory bank between the fetch stage (IF) and the data-memory stage (MEM) of the 5-stage pipeline CPU.
- Sequences each access through a small FSM with configurable wait states.
- Returns a one-cycle ready pulse to the winning requester. Stall control uses the losing requester's missing ready to freeze PC and the pipeline registers.
- Data accesses have priority; a starvation counter guarantees fetch progress.

Parameters:
ADDR_W, 8, memory address width (byte address; low 2 bits are passed through unchanged)
DATA_W, 32, data word width
WAIT_CYCLES, 1, cycles the address/control are held on the memory port (legal range 1..15)
STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win (legal range 1..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
if_req  in  1  fetch request; held with if_addr until if_ready
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction, valid only while if_ready=1
if_ready  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ready
d_we  in  1  1=write, 0=read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  read data, valid only while d_ready=1 and the access was a read; 0 otherwise
d_ready  out  1  one-cycle completion pulse for data
mem_en  out  1  memory port enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, combinational from mem_addr
busy  out  1  1 in ACCESS or RESP

Behaviour:
Reset (rst_n=0 at a clock edge):
- Next cycle: state=IDLE; counters=0; all outputs 0.
- This holds even in the middle of an access. No ready pulse is issued for the aborted access.

Grant (evaluated in IDLE only):
- d_req&&(starve<STARVE_MAX): grant DATA.
- else if_req: grant IF.
- else d_req: grant DATA.
- Neither request: stay IDLE.

Starvation counter:
- Increments, saturating at STARVE_MAX, when both requests are present and DATA wins.
- Clears when IF is granted.
- Holds otherwise.

FSM IDLE -> ACCESS -> RESP -> IDLE:
- IDLE, on grant: latch grant id, address, we and wdata into internal registers; go to ACCESS with wcnt=0.
- ACCESS:
  - mem_en=1; mem_addr/mem_we/mem_wdata driven from the latched registers.
  - mem_we=1 only for a DATA write.
  - wcnt increments each cycle.
  - When wcnt==WAIT_CYCLES-1: capture mem_rdata into the response register and go to RESP.
- RESP:
  - mem_en=0.
  - Pulse the granted ready for exactly one cycle, with rdata driven from the response register. For writes, rdata=0.
  - Next state is always IDLE. No back-to-back grant in the same cycle.

Latency and timing:
- Request seen in IDLE at edge N gives ready high in cycle N+WAIT_CYCLES+1.
- Minimum issue interval is WAIT_CYCLES+2 cycles.
- A request still high in the cycle after its ready pulse is treated as a new request.
- Requester inputs are sampled only at grant. Changes during ACCESS/RESP are ignored.
- The losing request stays pending; no request is ever dropped.
- All outputs are registered except mem_* (decoded from state and latched registers).

Optional Feature:
- Macro: ARB_PERF_EN.
- Defined:
  - Adds outputs if_wait_cnt[15:0] and d_wait_cnt[15:0].
  - Each counts cycles where its req=1 and its ready=0.
  - Counters saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg:
  - State encoding arb_state_t (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2).
  - Grant id encoding (GNT_IF=1'b0, GNT_D=1'b1).
  - Constants for maximum WAIT_CYCLES/STARVE_MAX (15).
- Sub-module arb_starve_ctr: 4-bit saturating starvation counter with inc/clr/sat outputs.

Test Plan:
- Single fetch, WAIT_CYCLES=1: if_req=1, if_addr=8'h04, mem holds 32'h8C010000 at 8'h04 -> mem_en=1 in cycle 1; if_ready=1 with if_rdata=32'h8C010000 in cycle 2; d_ready stays 0.
- Simultaneous requests: if_req=d_req=1, d_we=1, d_addr=8'h10, d_wdata=32'hDEADBEEF -> data granted first, with mem_we=1 and mem_addr=8'h10 during ACCESS; d_ready pulses; fetch granted next; if_ready arrives 3 cycles after d_ready.
- Starvation, STARVE_MAX=4: d_req held continuously, if_req held -> exactly 4 data grants, then 1 fetch grant; the pattern repeats.
- Reset mid-access, WAIT_CYCLES=3: assert rst_n=0 in the 2nd ACCESS cycle -> next cycle mem_en=0, busy=0, no ready pulse; after release, the still-held request restarts from IDLE.
- Write response: d_we=1 -> d_ready=1 with d_rdata=0; a later read of the same address returns the written word.
- With ARB_PERF_EN, WAIT_CYCLES=1: fetch blocked behind one data access -> if_wait_cnt=5 at its ready (3 cycles blocked plus 2 cycles of own latency).
